// File: rtl/spi_adc_4ch.sv
// SPI master for a 4-channel 12-bit ADC: one start pulse sweeps ch0..ch3 and
// publishes all four results together with a one-cycle end-of-sequence strobe.
module spi_adc_4ch #(
  parameter int HALF_DIV   = 20,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              dclk_o,
  output logic              cs_o,
  output logic              eos_o,
  output logic [DATA_W-1:0] doutch0_o,
  output logic [DATA_W-1:0] doutch1_o,
  output logic [DATA_W-1:0] doutch2_o,
  output logic [DATA_W-1:0] doutch3_o
);

  localparam int CNT_W = $clog2(2 * HALF_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(2 * HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [BIT_W-1:0]            bit_reg, bit_next;
  logic [1:0]                  ch_reg, ch_next;
  logic                        cs_reg, cs_next;
  logic                        dclk_reg, dclk_next;
  logic                        mosi_reg, mosi_next;
  logic                        eos_reg, eos_next;
  logic [FRAME_BITS-1:0]       piso_reg, piso_next;
  logic [DATA_W-1:0]           sipo_reg, sipo_next;
  logic [3:0][DATA_W-1:0]      shadow_reg, shadow_next;
  logic [3:0][DATA_W-1:0]      dout_reg, dout_next;

  // Command frame: two zero bits, channel address, then zero padding.
  function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [1:0] ch);
    cmd_word = '0;
    cmd_word[DATA_W +: 2] = ch;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      ch_reg     <= '0;
      cs_reg     <= 1'b1;
      dclk_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
      eos_reg    <= 1'b0;
      piso_reg   <= '0;
      sipo_reg   <= '0;
      shadow_reg <= '0;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      ch_reg     <= ch_next;
      cs_reg     <= cs_next;
      dclk_reg   <= dclk_next;
      mosi_reg   <= mosi_next;
      eos_reg    <= eos_next;
      piso_reg   <= piso_next;
      sipo_reg   <= sipo_next;
      shadow_reg <= shadow_next;
      dout_reg   <= dout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    ch_next     = ch_reg;
    cs_next     = cs_reg;
    dclk_next   = dclk_reg;
    mosi_next   = mosi_reg;
    eos_next    = 1'b0;
    piso_next   = piso_reg;
    sipo_next   = sipo_reg;
    shadow_next = shadow_reg;
    dout_next   = dout_reg;

    case (state_reg)
      IDLE: begin
        cs_next   = 1'b1;
        dclk_next = 1'b0;
        mosi_next = 1'b0;
        if (start_i) begin
          state_next = CS_SETUP;
          ch_next    = 2'd0;
          cnt_next   = '0;
          cs_next    = 1'b0;
          piso_next  = cmd_word(2'd0);
          mosi_next  = piso_next[FRAME_BITS-1];
        end
      end

      CS_SETUP: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = SHIFT;
          cnt_next   = '0;
          bit_next   = '0;
          dclk_next  = 1'b1;
          sipo_next  = {sipo_reg[DATA_W-2:0], miso_i};
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (dclk_reg) begin
            dclk_next = 1'b0;
            piso_next = piso_reg << 1;
            mosi_next = piso_next[FRAME_BITS-1];
          end else if (bit_reg == BIT_LAST) begin
            // Low half after the last falling edge is over: close the frame.
            state_next          = CS_HOLD;
            cs_next             = 1'b1;
            mosi_next           = 1'b0;
            shadow_next[ch_reg] = sipo_reg;
          end else begin
            bit_next  = bit_reg + 1'b1;
            dclk_next = 1'b1;
            sipo_next = {sipo_reg[DATA_W-2:0], miso_i};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      CS_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next = '0;
          if (ch_reg == 2'd3) begin
            state_next = DONE;
            eos_next   = 1'b1;
            dout_next  = shadow_reg;
          end else begin
            state_next = CS_SETUP;
            ch_next    = ch_reg + 2'd1;
            cs_next    = 1'b0;
            piso_next  = cmd_word(ch_reg + 2'd1);
            mosi_next  = piso_next[FRAME_BITS-1];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign cs_o      = cs_reg;
  assign dclk_o    = dclk_reg;
  assign mosi_o    = mosi_reg;
  assign eos_o     = eos_reg;
  assign doutch0_o = dout_reg[0];
  assign doutch1_o = dout_reg[1];
  assign doutch2_o = dout_reg[2];
  assign doutch3_o = dout_reg[3];

endmodule

// File: tb/tb_spi_adc_4ch.sv
// Bench for spi_adc_4ch: an event-driven ADC model answers each frame with data
// for the channel it decodes from MOSI; sweeps are checked against that data.
module tb_spi_adc_4ch;
  localparam int HALF_DIV   = 20;
  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int CLK_T      = 10;
  localparam int SWEEP_CLKS = 4 * (HALF_DIV + FRAME_BITS * 2 * HALF_DIV + 2 * HALF_DIV);
  localparam int DCLK_T     = 2 * HALF_DIV * CLK_T;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic miso = 1'b0;
  logic mosi, dclk, cs, eos;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic [DATA_W-1:0] dout_obs [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eos_cnt = 0;

  logic [DATA_W-1:0] adc_data [4];
  logic [DATA_W-1:0] exp_out [4];

  // ADC model / bus monitor state
  logic [15:0] rx_sr = '0;
  int          rx_n = 0;
  logic [1:0]  adc_ch = '0;
  logic        dclk_q = 1'b0;
  logic        cs_q = 1'b1;
  longint      last_rise = 0;
  longint      fmin = 0;
  longint      fmax = 0;
  int          cs_falls = 0;
  logic [15:0] frames [$];
  int          rises [$];
  longint      per_min_q [$];
  longint      per_max_q [$];

  spi_adc_4ch #(.HALF_DIV(HALF_DIV), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .miso_i(miso),
    .mosi_o(mosi), .dclk_o(dclk), .cs_o(cs), .eos_o(eos),
    .doutch0_o(d0), .doutch1_o(d1), .doutch2_o(d2), .doutch3_o(d3)
  );

  assign dout_obs[0] = d0;
  assign dout_obs[1] = d1;
  assign dout_obs[2] = d2;
  assign dout_obs[3] = d3;

  always #(CLK_T / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eos) eos_cnt <= eos_cnt + 1;

  always @(posedge cs or negedge cs or posedge dclk or negedge dclk) begin
    logic [DATA_W-1:0] word;
    if (!dclk_q && dclk) begin
      if (rx_n > 0) begin
        if ($time - last_rise < fmin) fmin = $time - last_rise;
        if ($time - last_rise > fmax) fmax = $time - last_rise;
      end
      last_rise = $time;
      rx_sr = {rx_sr[14:0], mosi};
      rx_n++;
      if (rx_n == 4) adc_ch = rx_sr[1:0];
    end
    if (dclk_q && !dclk) begin
      if (rx_n >= 4 && rx_n <= 15) begin
        word = adc_data[adc_ch];
        miso = word[15 - rx_n];
      end else begin
        miso = 1'b0;
      end
    end
    if (cs_q && !cs) begin
      rx_n = 0;
      rx_sr = '0;
      miso = 1'b0;
      fmin = 64'd1 << 40;
      fmax = 0;
      cs_falls++;
    end
    if (!cs_q && cs) begin
      frames.push_back(rx_sr);
      rises.push_back(rx_n);
      per_min_q.push_back(fmin);
      per_max_q.push_back(fmax);
    end
    dclk_q = dclk;
    cs_q = cs;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input int idx, input bit extra_start);
    int base_fr, base_eos, s, hold_bad;
    bit seen;
    base_fr = frames.size();
    base_eos = eos_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s = cyc;
    seen = 1'b0;
    hold_bad = 0;
    for (int k = 0; k < SWEEP_CLKS + 200; k++) begin
      if (eos) begin
        seen = 1'b1;
        break;
      end
      for (int c = 0; c < 4; c++) if (dout_obs[c] !== exp_out[c]) hold_bad++;
      start = extra_start && (k == 1000);
      @(negedge clk);
    end
    start = 1'b0;
    check_val("eos_seen", 32'(seen), 32'd1);
    check_val("eos_time", 32'(cyc - s), 32'(SWEEP_CLKS));
    check_val("hold_during_sweep", 32'(hold_bad), 32'd0);
    for (int c = 0; c < 4; c++) check_val($sformatf("dout%0d", c), 32'(dout_obs[c]), 32'(adc_data[c]));
    @(negedge clk);
    check_val("eos_width", 32'(eos), 32'd0);
    repeat (100) @(negedge clk);
    check_val("eos_count", 32'(eos_cnt - base_eos), 32'd1);
    check_val("frame_count", 32'(frames.size() - base_fr), 32'd4);
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("mosi_frame%0d", c), 32'(frames[base_fr + c]), 32'(c) << 12);
      check_val($sformatf("dclk_pulses%0d", c), 32'(rises[base_fr + c]), 32'd16);
      check_val($sformatf("dclk_min_period%0d", c), 32'(per_min_q[base_fr + c]), 32'(DCLK_T));
      check_val($sformatf("dclk_max_period%0d", c), 32'(per_max_q[base_fr + c]), 32'(DCLK_T));
    end
    for (int c = 0; c < 4; c++) exp_out[c] = adc_data[c];
    for (int c = 0; c < 4; c++) check_val($sformatf("dout_held%0d", c), 32'(dout_obs[c]), 32'(exp_out[c]));
    $display("sweep %0d: data %03h %03h %03h %03h extra_start=%0d", idx,
             adc_data[0], adc_data[1], adc_data[2], adc_data[3], extra_start);
  endtask

  initial begin
    int base_eos, cf;
    bit reached;
    for (int c = 0; c < 4; c++) begin
      adc_data[c] = '0;
      exp_out[c] = '0;
    end

    // Reset for one clock, then idle with no start
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    check_val("rst_cs", 32'(cs), 32'd1);
    check_val("rst_dclk", 32'(dclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_eos", 32'(eos), 32'd0);
    for (int c = 0; c < 4; c++) check_val($sformatf("rst_dout%0d", c), 32'(dout_obs[c]), 32'd0);
    repeat (50) @(negedge clk);
    check_val("idle_no_cs_activity", 32'(cs_falls), 32'd0);
    check_val("idle_cs", 32'(cs), 32'd1);
    $display("reset: idle checks done");

    adc_data[0] = 12'hABC; adc_data[1] = 12'h123; adc_data[2] = 12'h800; adc_data[3] = 12'h001;
    run_sweep(1, 1'b0);
    for (int c = 0; c < 4; c++) adc_data[c] = 12'hFFF;
    run_sweep(2, 1'b0);
    for (int c = 0; c < 4; c++) adc_data[c] = 12'($urandom_range(0, 4095));
    run_sweep(3, 1'b1);
    for (int c = 0; c < 4; c++) adc_data[c] = 12'($urandom_range(0, 4095));
    run_sweep(4, 1'b0);

    // Reset in the middle of channel 2's shift phase
    for (int c = 0; c < 4; c++) adc_data[c] = 12'($urandom_range(0, 4095));
    base_eos = eos_cnt;
    cf = cs_falls;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < SWEEP_CLKS; k++) begin
      if (cs_falls == cf + 3) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("reach_ch2", 32'(reached), 32'd1);
    repeat (210) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_cs", 32'(cs), 32'd1);
    check_val("midrst_dclk", 32'(dclk), 32'd0);
    check_val("midrst_eos", 32'(eos), 32'd0);
    for (int c = 0; c < 4; c++) check_val($sformatf("midrst_dout%0d", c), 32'(dout_obs[c]), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 4; c++) exp_out[c] = '0;
    repeat (SWEEP_CLKS + 100) @(negedge clk);
    check_val("midrst_no_eos", 32'(eos_cnt - base_eos), 32'd0);
    check_val("midrst_idle_cs", 32'(cs), 32'd1);
    $display("reset mid-sweep: checks done");

    for (int c = 0; c < 4; c++) adc_data[c] = 12'($urandom_range(0, 4095));
    run_sweep(5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
